debug_unit: RTL

Host-side debug controller sitting between the UART byte link and `Datapath`. Drives the datapath's debug interface: loads programs into instruction memory from a received byte stream, gates the pipeline `enable` for a run until halt, then streams data-memory contents back as bytes. It is the initiator for the debug ports `Datapath` responds to.

---
 rtl/debug_unit_pkg.sv | 33 +++
 rtl/debug_tx_serializer.sv | 88 ++++++++
 rtl/debug_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_pkg.sv
// Shared constants and state encodings for the host-side debug controller.
package debug_unit_pkg;

    localparam int unsigned DEF_PC_BITS          = 10;
    localparam int unsigned DEF_INSTRUCTION_BITS = 32;
    localparam int unsigned DEF_PROC_BITS        = 32;
    localparam int unsigned DEF_DATA_ADDRS_BITS  = 10;
    localparam int unsigned BYTE_BITS            = 8;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] ACK_LOAD = 8'h01;
    localparam logic [7:0] ACK_RUN  = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_WRITE,
        ST_ACK,
        ST_RUN,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_SEND
    } state_t;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_WAIT
    } ser_state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Sends a word (4 bytes) or its low byte (1 byte) MSB first over the tx
// byte handshake and pulses o_done once the last byte has been accepted.
module debug_tx_serializer
    import debug_unit_pkg::*;
#(
    parameter int unsigned PROC_BITS = DEF_PROC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_four,
    input  logic [PROC_BITS-1:0] i_word,
    input  logic                 i_tx_done,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_done
);

    localparam int unsigned LOW_SHIFT = PROC_BITS - BYTE_BITS;

    ser_state_t           state_q, state_d;
    logic [PROC_BITS-1:0] shift_q, shift_d;
    logic [PROC_BITS-1:0] first_c;
    logic [1:0]           left_q, left_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SER_IDLE;
            shift_q    <= '0;
            left_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
        end
    end

    // A single-byte send moves the low byte to the top so both cases shift out MSB first.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        left_d     = left_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        first_c    = i_four ? i_word : (i_word << LOW_SHIFT);

        case (state_q)
            SER_IDLE: begin
                if (i_start) begin
                    tx_data_d  = first_c[PROC_BITS-1 -: BYTE_BITS];
                    shift_d    = first_c << BYTE_BITS;
                    left_d     = i_four ? 2'd3 : 2'd0;
                    tx_start_d = 1'b1;
                    state_d    = SER_WAIT;
                end
            end
            SER_WAIT: begin
                if (i_tx_done) begin
                    if (left_q == 2'd0) begin
                        done_d  = 1'b1;
                        state_d = SER_IDLE;
                    end else begin
                        tx_data_d  = shift_q[PROC_BITS-1 -: BYTE_BITS];
                        shift_d    = shift_q << BYTE_BITS;
                        left_d     = left_q - 2'd1;
                        tx_start_d = 1'b1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Debug controller: loads instruction memory from the UART byte stream,
// gates the pipeline enable until halt, and dumps data memory back as bytes.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int unsigned PC_BITS          = DEF_PC_BITS,
    parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
    parameter int unsigned PROC_BITS        = DEF_PROC_BITS,
    parameter int unsigned DATA_ADDRS_BITS  = DEF_DATA_ADDRS_BITS,
    parameter int unsigned DUMP_WORDS       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_done,
    input  logic                        i_tx_done,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_start,
    output logic                        o_enable,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_debug_read_data,
    output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
    input  logic [PROC_BITS-1:0]        i_mem_data,
    input  logic                        i_halt,
    output logic                        o_busy
);

    localparam int unsigned ASM_BITS = INSTRUCTION_BITS - BYTE_BITS;
    localparam logic [DATA_ADDRS_BITS-1:0] LAST_ADDR = DATA_ADDRS_BITS'(DUMP_WORDS - 1);

    state_t                      state_q, state_d;
    logic [1:0]                  byte_cnt_q, byte_cnt_d;
    logic [7:0]                  words_left_q, words_left_d;
    logic [ASM_BITS-1:0]         asm_q, asm_d;
    logic [PC_BITS-1:0]          pc_q, pc_d;
    logic [DATA_ADDRS_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                        enable_q, enable_d;
    logic                        write_q, write_d;
    logic [PC_BITS-1:0]          inst_addr_q, inst_addr_d;
    logic [INSTRUCTION_BITS-1:0] inst_data_q, inst_data_d;
    logic                        rd_req_q, rd_req_d;
    logic                        busy_q, busy_d;

    logic                        ser_start_c;
    logic                        ser_four_c;
    logic [PROC_BITS-1:0]        ser_word_c;
    logic                        ser_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            words_left_q <= '0;
            asm_q        <= '0;
            pc_q         <= '0;
            rd_addr_q    <= '0;
            enable_q     <= 1'b0;
            write_q      <= 1'b0;
            inst_addr_q  <= '0;
            inst_data_q  <= '0;
            rd_req_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            words_left_q <= words_left_d;
            asm_q        <= asm_d;
            pc_q         <= pc_d;
            rd_addr_q    <= rd_addr_d;
            enable_q     <= enable_d;
            write_q      <= write_d;
            inst_addr_q  <= inst_addr_d;
            inst_data_q  <= inst_data_d;
            rd_req_q     <= rd_req_d;
            busy_q       <= busy_d;
        end
    end

    // Strobes are set on the transition into the state that owns them, so each
    // registered output lines up with the cycle its state is active.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        words_left_d = words_left_q;
        asm_d        = asm_q;
        pc_d         = pc_q;
        rd_addr_d    = rd_addr_q;
        enable_d     = 1'b0;
        write_d      = 1'b0;
        inst_addr_d  = inst_addr_q;
        inst_data_d  = inst_data_q;
        rd_req_d     = 1'b0;
        ser_start_c  = 1'b0;
        ser_four_c   = 1'b0;
        ser_word_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            pc_d    = '0;
                            state_d = ST_LOAD_CNT;
                        end
                        CMD_RUN: begin
                            enable_d = 1'b1;
                            state_d  = ST_RUN;
                        end
                        CMD_DUMP: begin
                            rd_addr_d = '0;
                            rd_req_d  = 1'b1;
                            state_d   = ST_RD_REQ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_done) begin
                    if (i_rx_data == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        words_left_d = i_rx_data;
                        byte_cnt_d   = 2'd0;
                        state_d      = ST_LOAD_BYTE;
                    end
                end
            end
            ST_LOAD_BYTE: begin
                if (i_rx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        write_d     = 1'b1;
                        inst_addr_d = pc_q;
                        inst_data_d = {asm_q, i_rx_data};
                        byte_cnt_d  = 2'd0;
                        state_d     = ST_WRITE;
                    end else begin
                        asm_d      = {asm_q[ASM_BITS-BYTE_BITS-1:0], i_rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_WRITE: begin
                pc_d         = pc_q + PC_BITS'(1);
                words_left_d = words_left_q - 8'd1;
                if (words_left_q == 8'd1) begin
                    ser_start_c = 1'b1;
                    ser_word_c  = PROC_BITS'(ACK_LOAD);
                    state_d     = ST_ACK;
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_ACK: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    ser_start_c = 1'b1;
                    ser_word_c  = PROC_BITS'(ACK_RUN);
                    state_d     = ST_ACK;
                end else begin
                    enable_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                ser_start_c = 1'b1;
                ser_four_c  = 1'b1;
                ser_word_c  = i_mem_data;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + DATA_ADDRS_BITS'(1);
                        rd_req_d  = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    debug_tx_serializer #(
        .PROC_BITS(PROC_BITS)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_start   (ser_start_c),
        .i_four    (ser_four_c),
        .i_word    (ser_word_c),
        .i_tx_done (i_tx_done),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .o_done    (ser_done)
    );

    assign o_enable             = enable_q;
    assign o_write_inst_mem     = write_q;
    assign o_inst_mem_addr      = inst_addr_q;
    assign o_inst_mem_data      = inst_data_q;
    assign o_debug_read_data    = rd_req_q;
    assign o_debug_read_address = rd_addr_q;
    assign o_busy               = busy_q;

endmodule
